// File: rtl/tt_sel_seq.sv
// Design-select sequencer: disables the design, resets the select counter, emits A increment pulses, then re-enables.
// Optional abort support is compiled in with `define TT_SEL_SEQ_ABORT_EN.
module tt_sel_seq #(
  parameter int ADDR_W = 10,
  parameter int PH_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic [PH_W-1:0]   cfg_phase,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              ctrl_ena,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc
);

  typedef enum logic [2:0] {
    S_IDLE, S_DIS, S_RST, S_GAP, S_INC_HI, S_INC_LO, S_ENA
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   timer_q, timer_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] a_q;
  logic [PH_W-1:0]   p_q;

  logic              abort_eff;
  logic              accept;
  logic              phase_end;
  logic [PH_W-1:0]   p_in;
  logic [ADDR_W-1:0] cnt_inc;

  logic ena_d, sel_rst_n_d, sel_inc_d, done_d, busy_d, ready_d;

`ifdef TT_SEL_SEQ_ABORT_EN
  assign abort_eff = abort;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_eff    = 1'b0;
`endif

  assign accept    = req_valid && req_ready && !abort_eff;
  assign phase_end = (timer_q == '0);
  assign p_in      = (cfg_phase == '0) ? PH_W'(1) : cfg_phase;
  assign cnt_inc   = cnt_q + ADDR_W'(1);

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_DIS;
        cnt_d   = '0;
      end
      S_DIS:    if (phase_end) state_d = S_RST;
      S_RST:    if (phase_end) state_d = S_GAP;
      S_GAP:    if (phase_end) state_d = (a_q == '0) ? S_ENA : S_INC_HI;
      S_INC_HI: if (phase_end) state_d = S_INC_LO;
      S_INC_LO: if (phase_end) begin
        cnt_d   = cnt_inc;
        state_d = (cnt_inc < a_q) ? S_INC_HI : S_ENA;
      end
      S_ENA:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort_eff && state_q != S_IDLE) state_d = S_IDLE;

    // Each phase restarts the countdown; the first one uses the value being latched at accept.
    if (state_d != state_q)
      timer_d = (state_q == S_IDLE) ? p_in - PH_W'(1) : p_q - PH_W'(1);
    else if (state_q == S_IDLE)
      timer_d = timer_q;
    else
      timer_d = timer_q - PH_W'(1);

    // Outputs are decoded from the next state and registered, so they line up with the state.
    ena_d       = ctrl_ena;
    sel_rst_n_d = (state_d != S_RST);
    sel_inc_d   = (state_d == S_INC_HI);
    done_d      = (state_d == S_ENA);
    busy_d      = (state_d != S_IDLE);
    ready_d     = (state_d == S_IDLE) && !abort_eff;
    unique case (state_d)
      S_ENA:  ena_d = 1'b1;
      S_IDLE: if (abort_eff && state_q != S_IDLE) ena_d = 1'b0;
      default: ena_d = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      cnt_q          <= '0;
      ctrl_ena       <= 1'b0;
      ctrl_sel_rst_n <= 1'b1;
      ctrl_sel_inc   <= 1'b0;
      done           <= 1'b0;
      busy           <= 1'b0;
      req_ready      <= 1'b1;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      cnt_q          <= cnt_d;
      ctrl_ena       <= ena_d;
      ctrl_sel_rst_n <= sel_rst_n_d;
      ctrl_sel_inc   <= sel_inc_d;
      done           <= done_d;
      busy           <= busy_d;
      req_ready      <= ready_d;
    end
  end

  // NOTE: the latched request is only read while busy and is always rewritten at accept, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= req_addr;
      p_q <= p_in;
    end
  end

endmodule
